adrv9009_rx_pfir: RTL and testbench
===================================

# adrv9009_rx_pfir

Parametrised, multi-channel, single-clock successor to the Rx programmable decimating FIR and its coefficient RAM. It sits after the half-band decimators in the ADRV9009 receive path. It filters NCH lock-step channels with one shared coefficient set, using a time-multiplexed MAC per channel. Tap count, decimation and gain are run-time configurable, and a bypass mode is provided.

## Interface
- DW, 16, sample width (signed, Q1.15 at DW=16)
- CW, 16, coefficient width (signed, Q1.(CW-1))
- NTAPS_MAX, 72, coefficient/sample memory depth
- NCH, 2, channel count
- AW, $clog2(NTAPS_MAX), address width
- clk_m  in  1  sole clock
- reset  in  1  synchronous, active-high
- in_data  in  NCH*DW  channel c at [c*DW +: DW]
- in_valid  in  1  sample strobe, common to all channels
- in_ready  out  1  sample accepted when in_valid && in_ready
- out_data  out  NCH*DW  filtered samples
- out_valid  out  1  one-cycle pulse per output
- en  in  1  1 = filter, 0 = bypass
- ntaps  in  AW+1  active taps
- deci  in  2  00 = /1, 01 = /2, 10 and 11 = /4
- gain  in  2  00 = -12 dB, 01 = -6 dB, 10 = 0 dB, 11 = +6 dB
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  AW  tap index k
- coef_data  in  CW  coefficient value
- coef_err  out  1  one-cycle pulse when a write is rejected

## Operation
- States: CLEAR, IDLE, MAC.
- CLEAR: entered on reset. Writes zeros to all NTAPS_MAX locations of every channel's sample buffer, one per cycle. in_ready = 0 throughout. Exits to IDLE after NTAPS_MAX cycles. Coefficient memory is not cleared.
- IDLE, en = 1:
  - On each accepted sample: write it to the circular sample buffer, then advance the write pointer, wrapping at NTAPS_MAX-1 → 0.
  - Phase counter counts up to the decimation factor minus 1. The sample that completes the count is the trigger.
  - On trigger: latch ntaps, gain and deci, reset the phase counter, go to MAC.
- ntaps clamping: 0 is treated as 1; values above NTAPS_MAX are treated as NTAPS_MAX.
- MAC:
  - For k = 0..ntaps-1, each channel accumulates coef[k] · x[n-k], where x[n] is the trigger sample. Buffer reads wrap below address 0.
  - After the final accumulate, emit the output and return to IDLE.
- Arithmetic:
  - Product width is DW+CW.
  - Accumulator width is DW+CW+AW+1; it cannot overflow.
  - Output = saturate(round(acc >>> S)), with S = CW-1+2 / CW-1+1 / CW-1 / CW-1-1 for gain 00/01/10/11.
  - Rounding: add 2^(S-1), then arithmetic shift (round half up).
  - Saturation bounds: [-2^(DW-1), 2^(DW-1)-1].
- Bypass (en = 0, state IDLE): out_data <= in_data and out_valid <= in_valid, registered. in_ready = 1. Phase counter is held at 0.
- Samples presented in bypass are not written to the buffer.
- en is sampled only in IDLE. A change of en during MAC takes effect after the current output.
- Coefficient writes:
  - Accepted only in IDLE, and take effect from the next trigger.
  - coef_wr in CLEAR or MAC is ignored and pulses coef_err the following cycle.
- Reset mid-MAC: the computation is aborted and there is no out_valid. The block enters CLEAR.
- Reset values: out_data = 0, out_valid = 0, coef_err = 0, in_ready = 0 (CLEAR), pointers and counters = 0.

## Timing
- Let the trigger sample be accepted at cycle T.
  - in_ready is 0 for cycles T+1 .. T+ntaps+4.
  - out_valid = 1 at cycle T+ntaps+4 only.
  - in_ready returns to 1 at cycle T+ntaps+5.
- Pipeline per tap: address → synchronous read (1 cycle) → registered multiply → accumulate → round/saturate register.
- Minimum spacing between trigger samples is ntaps+5 cycles.
- Non-trigger samples are accepted back-to-back.
- Bypass latency is 1 cycle.
- out_data holds its value between out_valid pulses.

## Structure
- Package adrv9009_rx_pkg holds:
  - state enum {CLEAR, IDLE, MAC}
  - gain and decimation encodings
  - accumulator-width and shift-amount functions
- Sub-module adrv9009_pfir_mac: one per channel, instantiated NCH times. Contains the multiply, accumulate, round and saturate logic.
- The control FSM, the pointers, and the shared coefficient memory stay in the top module.
- Sample buffers are inferred synchronous-read RAMs, one per channel.

## Test plan
- Reset release:
  - in_ready = 0 for exactly 72 cycles, then 1.
  - out_data = 0 and out_valid = 0 throughout.
- Impulse response:
  - Setup: ntaps = 4, coef = {16384, 8192, -8192, 4096}, deci = 01→00 (/1), gain = 10. Input ch0: 32767, then zeros.
  - Expected outputs: 16384, 8192, -8192, 4096, then 0.
  - ch1 fed -32768 returns -16384, -8192, 8192, -4096.
- Saturation:
  - Setup: 4 coefficients of 32767, gain = 11.
  - Constant input 32767 gives 32767; constant input -32768 gives -32768.
- Decimation /4:
  - Setup: ntaps = 1, coef[0] = 16384, gain = 11. Input ramp 1..16.
  - Expected: exactly 4 outputs, with values 4, 8, 12, 16.
- Backpressure:
  - Setup: in_valid held high, ntaps = 8, deci = /1.
  - Triggers accepted every 13 cycles; out_valid lands at T+12; no sample is lost or duplicated.
- Bypass and write rejection:
  - en = 0: out equals the input one cycle later.
  - coef_wr during MAC: coef_err pulses once, and the next output uses the old coefficient.

Source files
------------

// File: rtl/adrv9009_rx_pfir_pkg.sv
// Shared types, encodings and width/shift helpers for the Rx programmable decimating FIR.
package adrv9009_rx_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    MAC   = 2'd2
  } pfir_state_e;

  localparam logic [1:0] GAIN_M12DB = 2'b00;
  localparam logic [1:0] GAIN_M6DB  = 2'b01;
  localparam logic [1:0] GAIN_0DB   = 2'b10;
  localparam logic [1:0] GAIN_P6DB  = 2'b11;

  localparam logic [1:0] DECI_1 = 2'b00;
  localparam logic [1:0] DECI_2 = 2'b01;
  localparam logic [1:0] DECI_4 = 2'b10;

  function automatic int acc_width(input int dw, input int cw, input int aw);
    return dw + cw + aw + 1;
  endfunction

  function automatic int shift_amt(input logic [1:0] g, input int cw);
    case (g)
      GAIN_M12DB: return cw + 1;
      GAIN_M6DB:  return cw;
      GAIN_0DB:   return cw - 1;
      default:    return cw - 2;
    endcase
  endfunction

  // Last phase index before a trigger; 10 and 11 both select /4.
  function automatic logic [1:0] deci_last(input logic [1:0] d);
    case (d)
      DECI_1:  return 2'd0;
      DECI_2:  return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/adrv9009_rx_pfir_if.sv
// Sample stream in/out of the Rx FIR; master is the upstream source and output sink.
interface adrv9009_rx_pfir_if #(
  parameter int DW  = 16,
  parameter int NCH = 2
) ();
  logic [NCH*DW-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [NCH*DW-1:0] out_data;
  logic              out_valid;

  modport master (
    output in_data, in_valid,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/adrv9009_rx_pfir_mac.sv
// Per-channel multiply/accumulate with round-half-up and saturation to the sample width.
module adrv9009_pfir_mac
  import adrv9009_rx_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int AW = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] smp_p1,
  input  logic signed [CW-1:0] coef_p1,
  input  logic                 vld_p1,
  input  logic                 first_p1,
  input  logic                 last_p1,
  input  logic [1:0]           gain,
  output logic signed [DW-1:0] y,
  output logic                 done
);
  localparam int ACCW = acc_width(DW, CW, AW);
  localparam int PW   = DW + CW;
  localparam logic signed [ACCW:0] SAT_HI = {{(ACCW+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_LO = ~SAT_HI;

  logic signed [PW-1:0]   prod_p2;
  logic                   vld_p2, first_p2, last_p2;
  logic signed [ACCW-1:0] prod_ext_p2;
  logic signed [ACCW-1:0] acc_p3;

  function automatic logic signed [ACCW:0] round_shift(input logic signed [ACCW-1:0] a,
                                                       input logic [1:0] g);
    logic signed [ACCW:0] r;
    logic signed [ACCW:0] bias;
    int s;
    s    = shift_amt(g, CW);
    bias = {{ACCW{1'b0}}, 1'b1} << (s - 1);
    r    = {a[ACCW-1], a};
    r    = r + bias;
    return r >>> s;
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [ACCW:0] v);
    if (v > SAT_HI) return SAT_HI[DW-1:0];
    if (v < SAT_LO) return SAT_LO[DW-1:0];
    return v[DW-1:0];
  endfunction

  assign prod_ext_p2 = {{(ACCW-PW){prod_p2[PW-1]}}, prod_p2};

  // p1 -> p2: registered product; p2 -> p3: accumulate
  always_ff @(posedge clk) begin
    prod_p2 <= smp_p1 * coef_p1;
    if (vld_p2) acc_p3 <= first_p2 ? prod_ext_p2 : acc_p3 + prod_ext_p2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      first_p2 <= 1'b0;
      last_p2  <= 1'b0;
      done     <= 1'b0;
    end else begin
      vld_p2   <= vld_p1;
      first_p2 <= first_p1;
      last_p2  <= last_p1;
      done     <= vld_p2 && last_p2;
    end
  end

  assign y = saturate(round_shift(acc_p3, gain));

endmodule

// File: rtl/adrv9009_rx_pfir.sv
// Multi-channel Rx decimating FIR: control FSM, circular sample buffers, shared coefficient RAM.
module adrv9009_rx_pfir
  import adrv9009_rx_pkg::*;
#(
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int NTAPS_MAX = 72,
  parameter int NCH       = 2,
  parameter int AW        = $clog2(NTAPS_MAX)
) (
  input  logic                 clk_m,
  input  logic                 reset,
  adrv9009_rx_pfir_if.slave    strm,
  input  logic                 en,
  input  logic [AW:0]          ntaps,
  input  logic [1:0]           deci,
  input  logic [1:0]           gain,
  input  logic                 coef_wr,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 coef_err
);
  localparam logic [1:0]    ST_CLEAR = CLEAR;
  localparam logic [1:0]    ST_IDLE  = IDLE;
  localparam logic [1:0]    ST_MAC   = MAC;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NTAPS_MAX - 1);
  localparam logic [AW:0]   NT_MAX    = (AW+1)'(NTAPS_MAX);
  localparam logic [AW:0]   NT_ONE    = (AW+1)'(1);

  logic [1:0]    state;
  logic [AW-1:0] clr_cnt, wptr, rd_ptr, smp_waddr;
  logic [1:0]    phase, gain_l;
  logic [AW:0]   ntaps_l, ntaps_c, kcnt, k_last;
  logic          accept, trigger, smp_we, mac_done;
  logic          issue_p0, vld_p1, first_p1, last_p1;
  logic signed [CW-1:0] coef_mem [NTAPS_MAX];
  logic signed [CW-1:0] coef_p1;
  logic [NCH-1:0]       done_p3;
  logic [NCH*DW-1:0]    y_p3;

  assign strm.in_ready = (state == ST_IDLE);
  assign accept    = strm.in_valid && strm.in_ready;
  assign trigger   = accept && en && (phase >= deci_last(deci));
  assign smp_we    = (state == ST_CLEAR) || (accept && en);
  assign smp_waddr = (state == ST_CLEAR) ? clr_cnt : wptr;
  assign ntaps_c   = (ntaps == '0) ? NT_ONE : (ntaps > NT_MAX) ? NT_MAX : ntaps;
  assign k_last    = ntaps_l - 1'b1;
  assign mac_done  = &done_p3;

  // Writes only land in IDLE, so the MAC never reads a coefficient mid-update.
  always_ff @(posedge clk_m) begin
    if (coef_wr && state == ST_IDLE && coef_addr <= LAST_ADDR)
      coef_mem[coef_addr] <= coef_data;
    coef_p1 <= coef_mem[kcnt[AW-1:0]];
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [DW-1:0] buf_mem [NTAPS_MAX];
    logic signed [DW-1:0] smp_p1;

    // p0 -> p1: synchronous buffer read
    always_ff @(posedge clk_m) begin
      if (smp_we) buf_mem[smp_waddr] <= (state == ST_CLEAR) ? '0 : strm.in_data[c*DW +: DW];
      smp_p1 <= buf_mem[rd_ptr];
    end

    adrv9009_pfir_mac #(.DW(DW), .CW(CW), .AW(AW)) u_mac (
      .clk      (clk_m),
      .rst      (reset),
      .smp_p1   (smp_p1),
      .coef_p1  (coef_p1),
      .vld_p1   (vld_p1),
      .first_p1 (first_p1),
      .last_p1  (last_p1),
      .gain     (gain_l),
      .y        (y_p3[c*DW +: DW]),
      .done     (done_p3[c])
    );
  end

  always_ff @(posedge clk_m) begin
    if (reset) begin
      state          <= ST_CLEAR;
      clr_cnt        <= '0;
      wptr           <= '0;
      rd_ptr         <= '0;
      phase          <= '0;
      kcnt           <= '0;
      ntaps_l        <= '0;
      gain_l         <= '0;
      issue_p0       <= 1'b0;
      vld_p1         <= 1'b0;
      first_p1       <= 1'b0;
      last_p1        <= 1'b0;
      coef_err       <= 1'b0;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
    end else begin
      coef_err       <= coef_wr && (state != ST_IDLE);
      vld_p1         <= issue_p0;
      first_p1       <= issue_p0 && (kcnt == '0);
      last_p1        <= issue_p0 && (kcnt == k_last);
      strm.out_valid <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            clr_cnt <= '0;
            state   <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (!en) begin
            phase          <= '0;
            strm.out_valid <= strm.in_valid;
            if (strm.in_valid) strm.out_data <= strm.in_data;
          end else if (accept) begin
            wptr <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
            if (trigger) begin
              phase    <= '0;
              ntaps_l  <= ntaps_c;
              gain_l   <= gain;
              kcnt     <= '0;
              rd_ptr   <= wptr;
              issue_p0 <= 1'b1;
              state    <= ST_MAC;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        ST_MAC: begin
          // Walk backwards from the trigger sample, wrapping below address 0.
          if (issue_p0) begin
            rd_ptr <= (rd_ptr == '0) ? LAST_ADDR : rd_ptr - 1'b1;
            if (kcnt == k_last) issue_p0 <= 1'b0;
            else                kcnt     <= kcnt + 1'b1;
          end
          if (mac_done) begin
            strm.out_valid <= 1'b1;
            strm.out_data  <= y_p3;
          end
          if (strm.out_valid) state <= ST_IDLE;
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_adrv9009_rx_pfir.sv
// Directed bench for adrv9009_rx_pfir: reset clear, impulse, saturation, /4, backpressure, rejection, bypass.
module tb_adrv9009_rx_pfir;
  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic [7:0]         ntaps;
  logic [1:0]         deci, gain;
  logic               coef_wr;
  logic [6:0]         coef_addr;
  logic signed [15:0] coef_data;
  logic               coef_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ncap     = 0;
  logic signed [15:0] cap0 [64];
  logic signed [15:0] cap1 [64];
  int                 capcyc [64];

  adrv9009_rx_pfir_if #(.DW(16), .NCH(2)) strm ();

  adrv9009_rx_pfir dut (
    .clk_m     (clk),
    .reset     (reset),
    .strm      (strm),
    .en        (en),
    .ntaps     (ntaps),
    .deci      (deci),
    .gain      (gain),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (strm.out_valid) begin
      if (ncap < 64) begin
        cap0[ncap]   <= strm.out_data[15:0];
        cap1[ncap]   <= strm.out_data[31:16];
        capcyc[ncap] <= cyc;
      end
      ncap <= ncap + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wcoef(input logic [6:0] a, input logic signed [15:0] v);
    coef_wr   = 1'b1;
    coef_addr = a;
    coef_data = v;
    step();
    coef_wr = 1'b0;
    chk("coef_err_idle_write", coef_err, 0);
  endtask

  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b);
    strm.in_data  = {b, a};
    strm.in_valid = 1'b1;
    for (int i = 0; i < 200 && !strm.in_ready; i++) step();
    chk("send_ready", strm.in_ready, 1);
    step();
    strm.in_valid = 1'b0;
  endtask

  initial begin
    int base, nlow, nbad;
    int acc_cyc [6];
    int exp_imp0 [5] = '{16384, 8192, -8192, 4096, 0};
    int exp_imp1 [5] = '{-16384, -8192, 8192, -4096, 0};
    int exp_sat  [8] = '{32767, 32767, 32767, 32767, 32767, -4, -32768, -32768};

    reset = 1'b1; en = 1'b1; ntaps = 8'd4; deci = 2'b00; gain = 2'b10;
    coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
    strm.in_data = '0; strm.in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset release: buffer clear keeps in_ready low for NTAPS_MAX cycles
    nlow = 0; nbad = 0;
    while (!strm.in_ready && nlow < 200) begin
      if (strm.out_valid !== 1'b0 || strm.out_data !== 32'd0 || coef_err !== 1'b0) nbad++;
      nlow++;
      step();
    end
    chk("rst_ready_low_cycles", nlow, 72);
    chk("rst_outputs_zero", nbad, 0);
    chk("rst_ready_high", strm.in_ready, 1);

    // Impulse response
    wcoef(0, 16384); wcoef(1, 8192); wcoef(2, -8192); wcoef(3, 4096);
    ntaps = 8'd4; deci = 2'b00; gain = 2'b10;
    base = ncap;
    send(32767, -32768);
    repeat (4) send(0, 0);
    repeat (15) step();
    chk("imp_count", ncap - base, 5);
    for (int i = 0; i < 5; i++) begin
      chk("imp_ch0", cap0[base+i], exp_imp0[i]);
      chk("imp_ch1", cap1[base+i], exp_imp1[i]);
    end

    // Saturation
    for (int i = 0; i < 4; i++) wcoef(7'(i), 32767);
    gain = 2'b11;
    base = ncap;
    repeat (4) send(32767, 32767);
    repeat (4) send(-32768, -32768);
    repeat (15) step();
    chk("sat_count", ncap - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk("sat_ch0", cap0[base+i], exp_sat[i]);
      chk("sat_ch1", cap1[base+i], exp_sat[i]);
    end

    // Decimation by 4
    wcoef(0, 16384);
    ntaps = 8'd1; deci = 2'b10; gain = 2'b11;
    base = ncap;
    for (int k = 1; k <= 16; k++) send(16'(k), 16'(-k));
    repeat (15) step();
    chk("dec4_count", ncap - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk("dec4_ch0", cap0[base+i], 4 * (i + 1));
      chk("dec4_ch1", cap1[base+i], -4 * (i + 1));
    end

    // Backpressure with in_valid held high
    deci = 2'b00; ntaps = 8'd8;
    wcoef(0, 16384);
    for (int i = 1; i < 8; i++) wcoef(7'(i), 0);
    base = ncap;
    strm.in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      strm.in_data = {16'(-100 * i), 16'(100 * i)};
      for (int w = 0; w < 200 && !strm.in_ready; w++) step();
      chk("bp_ready", strm.in_ready, 1);
      acc_cyc[i] = cyc;
      step();
    end
    strm.in_valid = 1'b0;
    repeat (20) step();
    chk("bp_count", ncap - base, 5);
    for (int i = 1; i <= 5; i++) begin
      chk("bp_ch0", cap0[base+i-1], 100 * i);
      chk("bp_ch1", cap1[base+i-1], -100 * i);
      chk("bp_latency", capcyc[base+i-1] - acc_cyc[i], 12);
      if (i > 1) chk("bp_spacing", acc_cyc[i] - acc_cyc[i-1], 13);
    end

    // Coefficient write during MAC is rejected
    ntaps = 8'd1;
    base = ncap;
    send(1000, 0);
    coef_wr = 1'b1; coef_addr = 7'd0; coef_data = 16'sd8192;
    step();
    coef_wr = 1'b0;
    chk("rej_err_pulse", coef_err, 1);
    step();
    chk("rej_err_single", coef_err, 0);
    repeat (10) step();
    send(2000, 0);
    repeat (10) step();
    chk("rej_count", ncap - base, 2);
    chk("rej_first", cap0[base], 1000);
    chk("rej_old_coef", cap0[base+1], 2000);

    // Bypass
    en = 1'b0;
    step();
    chk("byp_ready", strm.in_ready, 1);
    strm.in_data = {16'(-7), 16'(5555)}; strm.in_valid = 1'b1;
    step();
    strm.in_valid = 1'b0;
    chk("byp_valid", strm.out_valid, 1);
    chk("byp_ch0", $signed(strm.out_data[15:0]), 5555);
    chk("byp_ch1", $signed(strm.out_data[31:16]), -7);
    strm.in_data = {16'sh7fff, 16'sh8000};
    step();
    chk("byp_valid_drop", strm.out_valid, 0);
    chk("byp_hold", $signed(strm.out_data[15:0]), 5555);
    strm.in_valid = 1'b1;
    step();
    strm.in_valid = 1'b0;
    chk("byp_valid2", strm.out_valid, 1);
    chk("byp2_ch0", $signed(strm.out_data[15:0]), -32768);
    chk("byp2_ch1", $signed(strm.out_data[31:16]), 32767);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
